// File: rtl/hiscore_bridge_leaf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hiscore_bridge_leaf                                                      |
// | High-score table in flops, shared by the APF bridge and the core; raises |
// | one debounced save request per burst of changing core writes.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hiscore_bridge_leaf #(
   parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
   parameter int          NUM_BYTES     = 83,
   parameter int          SETTLE_CYCLES = 74_250_000
) (
   input  logic        clk_74a,
   input  logic        reset,
   input  logic [31:0] bridge_addr,
   input  logic        bridge_wr,
   input  logic [31:0] bridge_wr_data,
   input  logic        bridge_rd,
   output logic [31:0] bridge_rd_data,
   input  logic [7:0]  core_addr,
   input  logic        core_wr,
   input  logic [7:0]  core_wdata,
   output logic [7:0]  core_rdata,
   output logic        hs_loaded,
   output logic        hs_dirty,
   output logic        hs_save_req,
   output logic [15:0] save_count
);

   localparam int                 c_CNT_W     = $clog2(SETTLE_CYCLES) + 1;
   localparam int                 c_LAST_WORD = (NUM_BYTES - 1) / 4;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_READY  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_REQ    = 2'd3
   } state_t;

   logic [NUM_BYTES*8-1:0] r_mem;
   logic [NUM_BYTES*8-1:0] w_mem_nxt;
   logic [31:0]            w_offset;
   logic [29:0]            w_word;
   logic                   w_unused;
   logic                   w_core_in;
   logic                   w_coll;
   logic                   w_core_chg;
   logic                   w_loaded_set;
   logic [7:0]             w_core_old;
   logic [31:0]            w_brd_word;
   logic [31:0]            r_brd;
   logic [7:0]             r_crd;
   logic                   r_loaded;
   logic [15:0]            r_save_cnt;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;
   state_t                 r_state;
   state_t                 w_state_nxt;

   // Addresses below BASE_ADDR wrap to huge offsets and match no stored word.
   assign w_offset = bridge_addr - BASE_ADDR;
   assign w_word   = w_offset[31:2];
   assign w_unused = &{1'b0, w_offset[1:0]};

   assign w_core_in    = ({1'b0, core_addr} < 9'(NUM_BYTES));
   assign w_coll       = bridge_wr && (w_word == {24'd0, core_addr[7:2]});
   assign w_core_chg   = core_wr && w_core_in && !w_coll && (core_wdata != w_core_old);
   assign w_loaded_set = bridge_wr && (w_word == 30'(c_LAST_WORD));

   always_comb begin
      w_core_old = 8'd0;
      w_brd_word = 32'd0;
      w_mem_nxt  = r_mem;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (core_addr == 8'(i)) begin
            w_core_old = r_mem[8*i +: 8];
         end
         if (w_word == 30'(i / 4)) begin
            w_brd_word[31 - 8*(i % 4) -: 8] = r_mem[8*i +: 8];
         end
         // Bridge beats core on a same-byte collision.
         if (bridge_wr && (w_word == 30'(i / 4))) begin
            w_mem_nxt[8*i +: 8] = bridge_wr_data[31 - 8*(i % 4) -: 8];
         end else if (core_wr && (core_addr == 8'(i))) begin
            w_mem_nxt[8*i +: 8] = core_wdata;
         end
      end
   end

   always_ff @(posedge clk_74a) begin
      if (reset) begin
         r_mem    <= '0;
         r_brd    <= 32'd0;
         r_crd    <= 8'd0;
         r_loaded <= 1'b0;
      end else begin
         r_mem    <= w_mem_nxt;
         r_crd    <= w_core_old;
         r_loaded <= r_loaded | w_loaded_set;
         if (bridge_rd) begin
            r_brd <= w_brd_word;
         end
      end
   end

   always_ff @(posedge clk_74a) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_cnt      <= '0;
         r_save_cnt <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if ((r_state == ST_REQ) && (r_save_cnt != 16'hFFFF)) begin
            r_save_cnt <= r_save_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_EMPTY: begin
            if (w_loaded_set) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            if (w_core_chg) begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = '0;
            end
         end
         ST_SETTLE: begin
            if (w_core_chg) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
         end
         ST_REQ: begin
            w_state_nxt = ST_READY;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = ST_EMPTY;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign bridge_rd_data = r_brd;
   assign core_rdata     = r_crd;
   assign hs_loaded      = r_loaded;
   assign hs_dirty       = (r_state == ST_SETTLE);
   assign hs_save_req    = (r_state == ST_REQ);
   assign save_count     = r_save_cnt;

endmodule
`default_nettype wire

// File: doc/hiscore_bridge_leaf.md
# hiscore_bridge_leaf

High-score table leaf on the APF bridge. It holds the 83-byte (0x53) high-score region in flip-flop storage. The host reaches it through bridge addresses 0x10000000–0x10000052 as a bridge_master leaf. Game logic inside the core reaches it through a byte port. The block tracks when game writes change the table and raises a debounced save request so the host-side save path runs once per burst of updates, not once per byte.

## Interface
Parameters:
- BASE_ADDR, 32'h10000000, first bridge byte address of the region
- NUM_BYTES, 83, table size in bytes (1..256)
- SETTLE_CYCLES, 74_250_000, quiet cycles after the last changing core write before a save request (1 s at clk_74a)

Ports:
- clk_74a  in  1  sole clock; bridge and core sides are both in this domain
- reset  in  1  synchronous, active-high
- bridge_addr  in  32  leaf address from bridge_master
- bridge_wr  in  1  one-cycle write strobe
- bridge_wr_data  in  32  write word, big-endian byte order
- bridge_rd  in  1  one-cycle read strobe
- bridge_rd_data  out  32  read word, big-endian
- core_addr  in  8  byte index
- core_wr  in  1  byte write strobe
- core_wdata  in  8  write byte
- core_rdata  out  8  read byte
- hs_loaded  out  1  host has written the final word of the table
- hs_dirty  out  1  table contains unsaved core changes
- hs_save_req  out  1  one-cycle save request pulse
- save_count  out  16  number of save requests issued, saturating

## Operation
- Storage: NUM_BYTES × 8 registers, all cleared to 0 on reset.
- Bridge word index: w = (bridge_addr − BASE_ADDR) >> 2.
- Bridge write covers bytes 4w..4w+3.
  - Byte 4w takes bridge_wr_data[31:24] and byte 4w+3 takes [7:0].
  - Bytes ≥ NUM_BYTES are dropped.
  - bridge_addr[1:0] is ignored.
- Bridge read returns the same byte packing. Bytes ≥ NUM_BYTES, and addresses outside the region, read 0.
- Core write: stores core_wdata at core_addr if core_addr < NUM_BYTES; otherwise it is ignored.
  - The write is "changing" if core_wdata differs from the stored byte.
- Core read: core_rdata returns the byte at core_addr, or 0 if out of range.
- Collision: bridge write and core write to the same byte in the same cycle → bridge data wins, and the core write counts as non-changing.
- hs_loaded: set by a bridge write whose word covers byte NUM_BYTES−1. It stays set until reset.
- State machine:
  - EMPTY (reset state): core writes are stored but never dirty the table. → READY when hs_loaded sets.
  - READY: a changing core write → SETTLE, with the quiet counter loaded to 0.
  - SETTLE: hs_dirty=1.
    - A changing core write resets the counter to 0.
    - Otherwise the counter increments.
    - When the counter reaches SETTLE_CYCLES−1 → REQ.
  - REQ: hs_save_req=1 for exactly one cycle; save_count increments, saturating at 16'hFFFF. → READY.
- Bridge writes never change state, and never reset the quiet counter.
- A non-changing core write in READY or SETTLE has no effect on state.

## Timing
- Reset values: bridge_rd_data=0, core_rdata=0, hs_loaded=0, hs_dirty=0, hs_save_req=0, save_count=0, state EMPTY, counter 0.
- Bridge write: storage is updated on the strobe edge and is visible to a core read issued in the next cycle.
- Bridge read: bridge_rd_data is registered and valid 1 cycle after bridge_rd, then held until the next bridge_rd.
- Core read: core_rdata is registered and valid 1 cycle after core_addr is sampled; it updates every cycle (no read strobe).
- Core read of a byte written in the same cycle returns the old value.
- Save request timing: a changing core write at cycle T with no further changes gives hs_save_req high at cycle T+SETTLE_CYCLES+1.
  - hs_dirty drops in the same cycle hs_save_req rises.
- hs_loaded rises 1 cycle after the final bridge write strobe. The EMPTY→READY transition occurs in the same cycle.
- Reset asserted mid-SETTLE: everything returns to reset values next cycle, and no save pulse is emitted.
- Counter width: ceil(log2(SETTLE_CYCLES))+1 bits; it never wraps.

## Test plan
- Reset, then bridge_rd at 0x10000000 → bridge_rd_data=0 one cycle later. hs_loaded=0, state EMPTY.
- Host load:
  - bridge writes 0x11223344 to 0x10000000 → core_rdata at core_addr 0..3 = 11, 22, 33, 44.
  - Write 0xAABBCCDD to 0x10000050 → bytes 80..82 = AA, BB, CC; DD is dropped; hs_loaded=1.
  - Reading back 0x10000050 returns 0xAABBCC00.
- Before hs_loaded: core write 0x55 at byte 5 → stored, hs_dirty stays 0, and no hs_save_req is ever issued.
- Debounce, with SETTLE_CYCLES=8 and hs_loaded=1:
  - Changing core writes at T and T+5 → hs_dirty=1 from T+1.
  - Single hs_save_req at T+14; save_count=1.
  - Rewriting an identical byte afterwards → no pulse.
- Collision: same cycle, bridge write to word 0 with 0x01020304 and core write 0xFF to byte 2 → byte 2 = 0x03 and state stays READY.
- Reset during SETTLE → hs_dirty=0, save_count unchanged from 0, and no pulse within 2×SETTLE_CYCLES afterwards.
